// File: rtl/packet_hash_stripper_if.sv
// ============================================================================
//  Module      : packet_hash_stripper_if
//  Description : AXI4-Stream bundle (data, strobe, user, valid, last, ready)
//                used on both sides of packet_hash_stripper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface packet_hash_stripper_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 128
) ();
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tstrb;
    logic [USER_WIDTH-1:0]   tuser;
    logic                    tvalid;
    logic                    tlast;
    logic                    tready;

    modport master (
        output tdata, tstrb, tuser, tvalid, tlast,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tuser, tvalid, tlast,
        output tready
    );
endinterface

`default_nettype wire

// File: rtl/packet_hash_stripper.sv
// ============================================================================
//  Module      : packet_hash_stripper
//  Description : Removes a HASH_BYTES-byte trailer from the end of each packet,
//                shortens the tuser length field, forwards the payload and
//                presents the extracted hash on a sideband with a strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module packet_hash_stripper #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int HASH_WIDTH           = 128
) (
    input  logic                    axi_aclk,
    input  logic                    axi_resetn,
    packet_hash_stripper_if.slave   s_axis,
    packet_hash_stripper_if.master  m_axis,
    input  logic                    strip_en,
    output logic [HASH_WIDTH-1:0]   hash_out,
    output logic                    hash_valid,
    output logic                    hash_err
);

    localparam int DW  = C_S_AXIS_DATA_WIDTH;
    localparam int MDW = C_M_AXIS_DATA_WIDTH;
    localparam int UW  = C_S_AXIS_TUSER_WIDTH;
    localparam int MUW = C_M_AXIS_TUSER_WIDTH;
    localparam int DB  = DW / 8;
    localparam int MDB = MDW / 8;
    localparam int HB  = HASH_WIDTH / 8;
    localparam int CW  = $clog2(DB) + 1;   // holds a byte count 0..DB
    localparam int OW  = CW + 1;           // holds a byte offset 0..2*DB

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Strobe with the k leading (wire-first) lanes set.
    function automatic logic [DB-1:0] lead_ones(input logic [CW-1:0] k);
        logic [DB-1:0] m;
        for (int i = 0; i < DB; i++) begin
            m[i] = ((DB - 1 - i) < int'(k));
        end
        return m;
    endfunction

    state_t                  state_q;
    logic [DW-1:0]           buf_data_q;
    logic [DB-1:0]           buf_strb_q;
    logic                    flush_pend_q;   // buffer holds the final beat while in FLUSH
    logic                    ctx_strip_q;
    logic [MUW-1:0]          ctx_user_q;

    logic [MDW-1:0]          m_tdata_q;
    logic [MDB-1:0]          m_tstrb_q;
    logic [MUW-1:0]          m_tuser_q;
    logic                    m_tvalid_q;
    logic                    m_tlast_q;

    // Sideband result of the packet whose tlast is still in flight.
    logic                    pend_valid_q;
    logic                    pend_err_q;
    logic [HASH_WIDTH-1:0]   pend_hash_q;

    logic [HASH_WIDTH-1:0]   hash_q;
    logic                    hash_valid_q;
    logic                    hash_err_q;

    logic                    w_in_fire;
    logic                    w_out_fire;
    logic                    w_first;
    logic [CW-1:0]           w_n;
    logic                    w_stop;
    logic [UW-1:0]           w_user_adj;
    logic [2*DW-1:0]         w_cat;
    logic [OW-1:0]           w_rsh;
    logic [HASH_WIDTH-1:0]   w_hash;

    assign s_axis.tready = axi_resetn && (state_q != S_FLUSH) && (!m_tvalid_q || m_axis.tready);

    assign w_in_fire  = s_axis.tvalid && s_axis.tready;
    assign w_out_fire = m_tvalid_q && m_axis.tready;
    assign w_first    = (state_q == S_EMPTY);

    assign w_user_adj = {s_axis.tuser[UW-1:16], s_axis.tuser[15:0] - 16'(HB)};

    // Valid byte count of the incoming beat: leading ones of the strobe.
    always_comb begin
        w_n    = '0;
        w_stop = 1'b0;
        for (int i = DB - 1; i >= 0; i--) begin
            if (!w_stop && s_axis.tstrb[i]) begin
                w_n = w_n + CW'(1);
            end else begin
                w_stop = 1'b1;
            end
        end
    end

    // Trailer window: the HB bytes ending at the last valid byte of
    // {buffered beat, last beat}; a single-beat packet sits in the upper half.
    always_comb begin
        if (w_first) begin
            w_cat = {s_axis.tdata, {DW{1'b0}}};
            w_rsh = OW'(2 * DB) - OW'(w_n);
        end else begin
            w_cat = {buf_data_q, s_axis.tdata};
            w_rsh = OW'(DB) - OW'(w_n);
        end
        w_hash = HASH_WIDTH'(w_cat >> {w_rsh, 3'b000});
    end

    // Packet FSM, holding buffer, output register and hash sideband.
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state_q      <= S_EMPTY;
            buf_data_q   <= '0;
            buf_strb_q   <= '0;
            flush_pend_q <= 1'b0;
            ctx_strip_q  <= 1'b0;
            ctx_user_q   <= '0;
            m_tdata_q    <= '0;
            m_tstrb_q    <= '0;
            m_tuser_q    <= '0;
            m_tvalid_q   <= 1'b0;
            m_tlast_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_err_q   <= 1'b0;
            pend_hash_q  <= '0;
            hash_q       <= '0;
            hash_valid_q <= 1'b0;
            hash_err_q   <= 1'b0;
        end else begin
            hash_valid_q <= 1'b0;
            hash_err_q   <= 1'b0;

            // Output drains; a load below overrides the clear.
            if (w_out_fire) begin
                m_tvalid_q <= 1'b0;
                if (m_tlast_q) begin
                    hash_valid_q <= pend_valid_q;
                    hash_err_q   <= pend_err_q;
                    if (pend_valid_q) begin
                        hash_q <= pend_hash_q;
                    end
                end
            end

            case (state_q)
                S_EMPTY: begin
                    if (w_in_fire) begin
                        ctx_strip_q <= strip_en;
                        ctx_user_q  <= strip_en ? w_user_adj : s_axis.tuser;
                        if (!s_axis.tlast) begin
                            buf_data_q <= s_axis.tdata;
                            buf_strb_q <= s_axis.tstrb;
                            state_q    <= S_HOLD;
                        end else begin
                            // Single-beat packet goes straight to the output.
                            m_tdata_q    <= s_axis.tdata;
                            m_tvalid_q   <= 1'b1;
                            m_tlast_q    <= 1'b1;
                            pend_valid_q <= 1'b0;
                            pend_err_q   <= 1'b0;
                            if (strip_en && (w_n > CW'(HB))) begin
                                m_tstrb_q    <= lead_ones(w_n - CW'(HB));
                                m_tuser_q    <= w_user_adj;
                                pend_valid_q <= 1'b1;
                                pend_hash_q  <= w_hash;
                                flush_pend_q <= 1'b0;
                                state_q      <= S_FLUSH;
                            end else begin
                                m_tstrb_q  <= s_axis.tstrb;
                                m_tuser_q  <= s_axis.tuser;
                                pend_err_q <= strip_en;
                            end
                        end
                    end
                end

                S_HOLD: begin
                    if (w_in_fire) begin
                        // Any arriving beat releases the buffered one.
                        m_tdata_q  <= buf_data_q;
                        m_tstrb_q  <= buf_strb_q;
                        m_tuser_q  <= ctx_user_q;
                        m_tvalid_q <= 1'b1;
                        m_tlast_q  <= 1'b0;
                        if (!s_axis.tlast) begin
                            buf_data_q <= s_axis.tdata;
                            buf_strb_q <= s_axis.tstrb;
                        end else begin
                            pend_valid_q <= 1'b0;
                            pend_err_q   <= 1'b0;
                            if (!ctx_strip_q) begin
                                buf_data_q   <= s_axis.tdata;
                                buf_strb_q   <= s_axis.tstrb;
                                flush_pend_q <= 1'b1;
                                state_q      <= S_FLUSH;
                            end else begin
                                pend_valid_q <= 1'b1;
                                pend_hash_q  <= w_hash;
                                if (w_n > CW'(HB)) begin
                                    buf_data_q   <= s_axis.tdata;
                                    buf_strb_q   <= lead_ones(w_n - CW'(HB));
                                    flush_pend_q <= 1'b1;
                                    state_q      <= S_FLUSH;
                                end else if (w_n == CW'(HB)) begin
                                    m_tlast_q <= 1'b1;
                                    state_q   <= S_EMPTY;
                                end else begin
                                    // Trailer reaches back into the buffered beat.
                                    m_tstrb_q <= lead_ones(CW'(DB - HB) + w_n);
                                    m_tlast_q <= 1'b1;
                                    state_q   <= S_EMPTY;
                                end
                            end
                        end
                    end
                end

                S_FLUSH: begin
                    if (w_out_fire) begin
                        if (flush_pend_q) begin
                            m_tdata_q  <= buf_data_q;
                            m_tstrb_q  <= buf_strb_q;
                            m_tuser_q  <= ctx_user_q;
                            m_tvalid_q <= 1'b1;
                            m_tlast_q  <= 1'b1;
                        end
                        flush_pend_q <= 1'b0;
                        state_q      <= S_EMPTY;
                    end
                end

                default: begin
                    state_q <= S_EMPTY;
                end
            endcase
        end
    end

    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tstrb  = m_tstrb_q;
    assign m_axis.tuser  = m_tuser_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;

    assign hash_out   = hash_q;
    assign hash_valid = hash_valid_q;
    assign hash_err   = hash_err_q;

endmodule

`default_nettype wire

// File: tb/tb_packet_hash_stripper.sv
// ============================================================================
//  Module      : tb_packet_hash_stripper
//  Description : Self-checking bench for packet_hash_stripper: byte-level
//                packet model, per-cycle output compare, directed literals.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_packet_hash_stripper;

    localparam int HB = 16;

    logic         clk;
    logic         rst_n;
    logic         strip_en;
    logic [127:0] hash_out;
    logic         hash_valid;
    logic         hash_err;

    packet_hash_stripper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
    packet_hash_stripper_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

    packet_hash_stripper dut (
        .axi_aclk   (clk),
        .axi_resetn (rst_n),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .strip_en   (strip_en),
        .hash_out   (hash_out),
        .hash_valid (hash_valid),
        .hash_err   (hash_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  strb;
        logic         last;
        logic [127:0] user;
        int           kind;   // 0 none, 1 hash_valid, 2 hash_err
        logic [127:0] hash;
    } exp_t;

    exp_t         exp_q[$];
    logic [7:0]   pkt [0:511];
    int           checks = 0;
    int           failures = 0;

    // Monitor-side state
    bit           pend_chk = 0;
    int           pend_kind = 0;
    logic [127:0] pend_hash = '0;
    logic [127:0] model_hash = '0;
    bit           stall_prev = 0;
    logic [255:0] sv_data;
    logic [31:0]  sv_strb;
    logic [127:0] sv_user;
    logic         sv_last;
    int           beats_cur = 0;
    int           pkt_beats = 0;
    logic [31:0]  last_strb = '0;
    logic [127:0] last_user = '0;
    int           hv_cnt = 0;
    int           he_cnt = 0;
    bit           ready_rand = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected output of one packet, computed from its bytes.
    function automatic void model_push(input int len, input logic [127:0] user_in, input bit strip);
        int           out_len;
        int           kind;
        int           nb;
        int           cnt;
        exp_t         e;
        logic [127:0] h;
        logic [127:0] user;
        h       = '0;
        user    = user_in;
        out_len = len;
        kind    = 0;
        if (strip && len > HB) begin
            kind    = 1;
            out_len = len - HB;
            for (int i = 0; i < HB; i++) h[127-8*i -: 8] = pkt[len-HB+i];
            user[15:0] = user[15:0] - 16'(HB);
        end else if (strip) begin
            kind = 2;
        end
        nb = (out_len + 31) / 32;
        for (int k = 0; k < nb; k++) begin
            cnt    = (out_len - 32*k > 32) ? 32 : out_len - 32*k;
            e.data = '0;
            e.strb = '0;
            for (int j = 0; j < cnt; j++) begin
                e.data[255-8*j -: 8] = pkt[32*k+j];
                e.strb[31-j]         = 1'b1;
            end
            e.last = (k == nb - 1);
            e.kind = e.last ? kind : 0;
            e.hash = h;
            e.user = user;
            exp_q.push_back(e);
        end
    endfunction

    // Output-side ready pattern, changed just after each rising edge.
    always @(posedge clk) begin
        #1;
        m_if.tready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: every cycle, sampled mid-cycle.
    always @(negedge clk) begin
        bit    chk_now;
        bit    exp_v;
        bit    exp_e;
        exp_t  e;
        logic [255:0] mask;
        if (!rst_n) begin
            pend_chk   = 0;
            stall_prev = 0;
            beats_cur  = 0;
            model_hash = '0;
        end else begin
            chk_now  = pend_chk;
            pend_chk = 0;
            exp_v    = chk_now && (pend_kind == 1);
            exp_e    = chk_now && (pend_kind == 2);
            chk("hash_valid", {255'd0, hash_valid}, {255'd0, exp_v});
            chk("hash_err", {255'd0, hash_err}, {255'd0, exp_e});
            if (hash_valid) hv_cnt++;
            if (hash_err) he_cnt++;
            if (exp_v) model_hash = pend_hash;
            if (chk_now) chk("hash_out", {128'd0, hash_out}, {128'd0, model_hash});
            if (stall_prev) begin
                chk("stall_tvalid", {255'd0, m_if.tvalid}, 256'd1);
                chk("stall_tdata", m_if.tdata, sv_data);
                chk("stall_tstrb", {224'd0, m_if.tstrb}, {224'd0, sv_strb});
                chk("stall_tuser", {128'd0, m_if.tuser}, {128'd0, sv_user});
                chk("stall_tlast", {255'd0, m_if.tlast}, {255'd0, sv_last});
            end
            if (m_if.tvalid && m_if.tready) begin
                beats_cur++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got output beat tdata=%h, expected no beat", m_if.tdata);
                    pend_kind = 0;
                end else begin
                    e = exp_q.pop_front();
                    for (int j = 0; j < 32; j++) mask[8*j +: 8] = {8{e.strb[j]}};
                    chk("tstrb", {224'd0, m_if.tstrb}, {224'd0, e.strb});
                    chk("tlast", {255'd0, m_if.tlast}, {255'd0, e.last});
                    chk("tuser", {128'd0, m_if.tuser}, {128'd0, e.user});
                    chk("tdata", m_if.tdata & mask, e.data & mask);
                    pend_kind = e.kind;
                    pend_hash = e.hash;
                end
                if (m_if.tlast) begin
                    pkt_beats = beats_cur;
                    beats_cur = 0;
                    last_strb = m_if.tstrb;
                    last_user = m_if.tuser;
                    pend_chk  = 1;
                end
            end
            stall_prev = m_if.tvalid && !m_if.tready;
            sv_data    = m_if.tdata;
            sv_strb    = m_if.tstrb;
            sv_user    = m_if.tuser;
            sv_last    = m_if.tlast;
        end
    end

    // Wait (bounded) until the current beat is accepted; returns after the edge.
    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (s_if.tready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got tready=0 for 2000 cycles, expected acceptance");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int len, input int k, input logic [127:0] user);
        int cnt;
        cnt = (len - 32*k > 32) ? 32 : len - 32*k;
        s_if.tdata = '0;
        s_if.tstrb = '0;
        for (int j = 0; j < cnt; j++) begin
            s_if.tdata[255-8*j -: 8] = pkt[32*k+j];
            s_if.tstrb[31-j]         = 1'b1;
        end
        s_if.tuser  = user;
        s_if.tlast  = (32*(k+1) >= len);
        s_if.tvalid = 1'b1;
    endtask

    task automatic fill_pkt(input int len, input bit pattern, output logic [127:0] user);
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        for (int i = 0; i < len; i++) pkt[i] = pattern ? 8'(i + 1) : 8'($urandom_range(0, 255));
        user = {r[127:16], 16'(len)};
    endtask

    task automatic send_packet(input int len, input bit strip, input bit toggle, input bit pattern);
        logic [127:0] user;
        int           nb;
        fill_pkt(len, pattern, user);
        model_push(len, user, strip);
        nb = (len + 31) / 32;
        for (int k = 0; k < nb; k++) begin
            set_beat(len, k, user);
            if (k == 0) strip_en = strip;
            wait_accept();
            if (k == 0 && toggle) strip_en = !strip;
        end
        s_if.tvalid = 1'b0;
    endtask

    task automatic drain();
        bit ok;
        ok = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] user;
        int           hv0;
        int           he0;
        rst_n       = 1'b0;
        strip_en    = 1'b0;
        s_if.tdata  = '0;
        s_if.tstrb  = '0;
        s_if.tuser  = '0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        m_if.tready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_tvalid", {255'd0, m_if.tvalid}, 256'd0);
        chk("rst_tdata", m_if.tdata, 256'd0);
        chk("rst_hash_out", {128'd0, hash_out}, 256'd0);
        chk("rst_tready", {255'd0, s_if.tready}, 256'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 3-beat packet, 80 bytes, trailer is exactly the last beat
        hv0 = hv_cnt;
        send_packet(80, 1, 0, 1);
        drain();
        chk("t1_beats", 256'(pkt_beats), 256'd2);
        chk("t1_strb", {224'd0, last_strb}, {224'd0, 32'hFFFFFFFF});
        chk("t1_len", {240'd0, last_user[15:0]}, 256'd64);
        chk("t1_hash", {128'd0, hash_out}, {128'd0, 128'h4142434445464748494A4B4C4D4E4F50});
        chk("t1_hv_count", 256'(hv_cnt - hv0), 256'd1);

        // 2-beat packet, 40 bytes, trailer spans both beats
        send_packet(40, 1, 0, 1);
        drain();
        chk("t2_beats", 256'(pkt_beats), 256'd1);
        chk("t2_strb", {224'd0, last_strb}, {224'd0, 32'hFFFFFF00});
        chk("t2_len", {240'd0, last_user[15:0]}, 256'd24);
        chk("t2_hash", {128'd0, hash_out}, {128'd0, 128'h191A1B1C1D1E1F202122232425262728});

        // Single-beat packets: 30 bytes trimmed in place, 12 bytes too short
        send_packet(30, 1, 0, 1);
        drain();
        chk("t3_strb", {224'd0, last_strb}, {224'd0, 32'hFFFC0000});
        chk("t3_len", {240'd0, last_user[15:0]}, 256'd14);
        chk("t3_hash", {128'd0, hash_out}, {128'd0, 128'h0F101112131415161718191A1B1C1D1E});
        he0 = he_cnt;
        send_packet(12, 1, 0, 1);
        drain();
        chk("t4_strb", {224'd0, last_strb}, {224'd0, 32'hFFF00000});
        chk("t4_len", {240'd0, last_user[15:0]}, 256'd12);
        chk("t4_hash_held", {128'd0, hash_out}, {128'd0, 128'h0F101112131415161718191A1B1C1D1E});
        chk("t4_he_count", 256'(he_cnt - he0), 256'd1);

        // strip_en drops mid-packet: this packet still stripped, the next one not
        send_packet(70, 1, 1, 0);
        drain();
        chk("t5_len", {240'd0, last_user[15:0]}, 256'd54);
        chk("t5_strb", {224'd0, last_strb}, {224'd0, 32'hFFFFFC00});
        hv0 = hv_cnt;
        send_packet(50, 0, 0, 0);
        drain();
        chk("t6_len", {240'd0, last_user[15:0]}, 256'd50);
        chk("t6_strb", {224'd0, last_strb}, {224'd0, 32'hFFFFC000});
        chk("t6_no_hv", 256'(hv_cnt - hv0), 256'd0);

        // Random lengths and strip settings under random back-pressure
        ready_rand = 1;
        for (int p = 0; p < 1000; p++) begin
            send_packet($urandom_range(1, 128), ($urandom_range(0, 9) < 7), 1'($urandom_range(0, 1)), 0);
        end
        drain();
        ready_rand = 0;
        drain();

        // Reset during beat 2 of a 4-beat packet
        fill_pkt(120, 0, user);
        set_beat(120, 0, user);
        strip_en = 1'b1;
        wait_accept();
        set_beat(120, 1, user);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mr_tvalid", {255'd0, m_if.tvalid}, 256'd0);
        chk("mr_tdata", m_if.tdata, 256'd0);
        chk("mr_tstrb", {224'd0, m_if.tstrb}, 256'd0);
        chk("mr_tuser", {128'd0, m_if.tuser}, 256'd0);
        chk("mr_tlast", {255'd0, m_if.tlast}, 256'd0);
        chk("mr_hash_out", {128'd0, hash_out}, 256'd0);
        chk("mr_hash_flags", {254'd0, hash_valid, hash_err}, 256'd0);
        chk("mr_tready", {255'd0, s_if.tready}, 256'd0);
        s_if.tvalid = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_packet(120, 1, 0, 0);
        drain();
        chk("ar_beats", 256'(pkt_beats), 256'd4);
        chk("ar_strb", {224'd0, last_strb}, {224'd0, 32'hFF000000});
        chk("ar_len", {240'd0, last_user[15:0]}, 256'd104);
        chk("ar_outstanding", 256'(exp_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/packet_hash_stripper.md
# packet_hash_stripper

Receive-side counterpart of the packet cutter in the OSNT monitor pipeline. It accepts cut packets that carry a HASH_BYTES-byte hash trailer as their last valid bytes. It removes the trailer, reduces the length field in tuser accordingly, forwards the shortened packet, and presents the extracted hash on a sideband with a one-cycle strobe. It sits after the cutter, or at the host/DMA end, so software receives the payload and the hash separately.

## Interface
- C_M_AXIS_DATA_WIDTH, 256, master data width; equals slave width.
- C_S_AXIS_DATA_WIDTH, 256, slave data width.
- C_M_AXIS_TUSER_WIDTH, 128, master tuser width.
- C_S_AXIS_TUSER_WIDTH, 128, slave tuser width; bits [15:0] carry the packet byte length.
- HASH_WIDTH, 128, trailer width in bits. HASH_BYTES = HASH_WIDTH/8 must be less than DATA_BYTES = data width/8.
- axi_aclk  in  1  single clock.
- axi_resetn  in  1  asynchronous, active-low reset.
- s_axis_tdata/tstrb/tuser/tvalid/tlast  in  256/32/128/1/1  input stream.
- s_axis_tready  out  1  input back-pressure.
- m_axis_tdata/tstrb/tuser/tvalid/tlast  out  256/32/128/1/1  output stream, all registered.
- m_axis_tready  in  1  output back-pressure.
- strip_en  in  1  1 = strip the trailer; 0 = pass packets through unmodified.
- hash_out  out  HASH_WIDTH  last extracted hash.
- hash_valid  out  1  one-cycle strobe when hash_out updates.
- hash_err  out  1  one-cycle strobe when a packet is too short to hold a trailer.

## Operation
- Byte order: lane DATA_BYTES-1 (bits [255:248]) is the first byte on the wire.
- tstrb is left-aligned. The valid count n of a beat is its number of leading ones. Non-last beats are always full.
- The trailer is the last HASH_BYTES valid bytes of the packet. The first trailer byte lands in hash_out[HASH_WIDTH-1:HASH_WIDTH-8].
- strip_en is sampled on the first beat of each packet and held for that packet.
- A one-word holding buffer provides look-ahead, because the trailer may span the last two beats.
- States:
  - EMPTY: buffer empty. Accepting the first beat goes to HOLD.
  - HOLD: one beat buffered. A non-last beat arriving releases the buffered beat to the output and takes its place.
  - FLUSH: a trimmed final beat is buffered and awaits output. Leaves to EMPTY on the output handshake.
- When the last beat arrives with valid count n (stripping enabled), and b is the buffered beat:
  - n > HASH_BYTES: emit b unchanged. Keep the last beat trimmed to n-HASH_BYTES bytes (tstrb = ones<<(DATA_BYTES-(n-HASH_BYTES))) and go to FLUSH.
  - n == HASH_BYTES: emit b with tlast=1 and full tstrb. The trailer is exactly the last beat. Go to EMPTY.
  - n < HASH_BYTES: emit b trimmed to DATA_BYTES-(HASH_BYTES-n) bytes with tlast=1. The trailer spans the tail of b and all of the last beat. Go to EMPTY.
- Single-beat packet with n > HASH_BYTES: trim in place to n-HASH_BYTES bytes and go to FLUSH.
- Single-beat packet with n ≤ HASH_BYTES: forward unmodified, pulse hash_err, leave hash_out unchanged.
- strip_en=0: every beat is forwarded unmodified through the same buffer, with no hash_valid.
- m_axis_tuser is the first beat's tuser on every beat of the packet. Bits [15:0] are reduced by HASH_BYTES when stripping; the subtraction is 16-bit unsigned.
- Trailer extraction concatenates {b, last beat} as a 512-bit vector and selects HASH_BYTES bytes ending at the last valid byte.

## Timing
- Reset values: all m_axis outputs, hash_out, hash_valid and hash_err are 0; state is EMPTY; s_axis_tready is 0 while in reset.
- Reset asserted mid-packet drops the buffered beat and the partial packet. The bench must restart on a packet boundary.
- Input handshake: s_axis_tready = (state != FLUSH) && (!m_axis_tvalid || m_axis_tready).
- Output rules:
  - m_axis_tvalid, once high, holds with stable data until m_axis_tready.
  - A beat is emitted on the cycle after the input handshake that releases it.
- Latency from input beat k to output beat k:
  - multi-beat packets: one beat plus one cycle, because the first output appears the cycle after beat 2 is accepted;
  - single-beat packets: one cycle.
- Throughput: one beat per cycle. FLUSH costs at most one s_axis_tready bubble per packet.
- hash_valid and hash_err pulse in the cycle the output tlast beat completes its handshake (m_axis_tvalid && m_axis_tready && m_axis_tlast). hash_out is updated in the same cycle and then held.
- Simultaneous input and output handshakes in HOLD are allowed without a bubble.

## Test plan
- 3-beat packet, tuser[15:0]=80, last n=16, HASH_WIDTH=128, strip_en=1 → 2 output beats, last tstrb=32'hFFFFFFFF, tlast on beat 2, tuser[15:0]=64, hash_out = the last beat's upper 16 bytes, one hash_valid.
- 2-beat packet, length 40 (last n=8) → 1 output beat with tstrb=32'hFFFFFF00 and tlast; hash_out = input bytes 24..39; tuser[15:0]=24.
- 1-beat packet, n=30 → tstrb=32'hFFFC0000, tlast, tuser 30→14. A second 1-beat packet with n=12 → unmodified, hash_err pulse, hash_out unchanged.
- strip_en toggled mid-packet from 1 to 0 → current packet stripped; the next packet passes through bit-exact with no hash_valid.
- Random m_axis_tready (50% duty) over 1000 random-length packets → output payload matches the reference model, no beat is lost or duplicated, and m_axis data stays stable while stalled.
- Reset asserted during beat 2 of a 4-beat packet → all outputs 0 the cycle after assertion; the next full packet after release is processed correctly.
